// File: rtl/safe_key_arb_if.sv
// rtl/safe_key_arb_if.sv - requester key handshake bundle for safe_key_arb
interface safe_key_arb_if;
    logic       req0_valid_i;
    logic [2:0] req0_key_i;
    logic       req0_ready_o;
    logic       req1_valid_i;
    logic [2:0] req1_key_i;
    logic       req1_ready_o;

    modport slave (
        input  req0_valid_i, req0_key_i, req1_valid_i, req1_key_i,
        output req0_ready_o, req1_ready_o
    );

    modport master (
        output req0_valid_i, req0_key_i, req1_valid_i, req1_key_i,
        input  req0_ready_o, req1_ready_o
    );
endinterface

// File: rtl/safe_key_arb.sv
// rtl/safe_key_arb.sv - two-requester keypad arbiter with ownership, fail counting and lockout
module safe_key_arb #(
    parameter int GAP_CYCLES     = 1,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int OWNER_IDLE     = 2000
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    safe_key_arb_if.slave         req_if,
    output logic                  KEY_0,
    output logic                  KEY_1,
    output logic                  KEY_2,
    output logic                  KEY_3,
    output logic                  KEY_OK,
    output logic                  KEY_CLEAR,
    output logic                  DOOR_SEALED,
    input  logic [2:0]            safe_out_i,
    input  logic                  safe_out_valid_i,
    output logic                  owner_valid_o,
    output logic                  owner_o,
    output logic                  lockout_o,
    output logic [2:0]            fail_cnt_o,
    output logic                  bad_key_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [2:0] ST_PASS_OK   = 3'd3;
    localparam logic [2:0] ST_PASS_FAIL = 3'd4;
    localparam logic [2:0] ST_TIMEOUT   = 3'd5;
    localparam logic [2:0] ST_CLOSE     = 3'd6;
    localparam logic [2:0] KEY_BAD      = 3'd7;

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int IW = $clog2(OWNER_IDLE + 1);

    localparam logic [2:0]    MAX_F     = 3'(MAX_FAILS);
    localparam logic [3:0]    GAP_LOAD  = 4'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(OWNER_IDLE - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    key_q, key_d;
    logic [3:0]    gap_q, gap_d;
    logic          last_q, last_d;
    logic          owner_valid_q, owner_valid_d;
    logic          owner_q, owner_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [2:0]    fail_q, fail_d;
    logic          lockout_q, lockout_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          bad_key_q, bad_key_d;

    logic       accepting, want0, want1, gnt0, gnt1, xfer, xfer_idx;
    logic [2:0] xfer_key;
    logic       st_fail, st_ok, st_release, trip, release_own;

    // Only the owner competes while a session is held; otherwise round-robin on last grant.
    always_comb begin
        accepting = arst_n_i && (state_q == S_IDLE) && !lockout_q;
        want0     = req_if.req0_valid_i && (!owner_valid_q || !owner_q);
        want1     = req_if.req1_valid_i && (!owner_valid_q ||  owner_q);
        gnt0      = accepting && want0 && (!want1 ||  last_q);
        gnt1      = accepting && want1 && (!want0 || !last_q);
        xfer      = gnt0 || gnt1;
        xfer_idx  = gnt1;
        xfer_key  = gnt1 ? req_if.req1_key_i : req_if.req0_key_i;
    end

    assign req_if.req0_ready_o = gnt0;
    assign req_if.req1_ready_o = gnt1;

    always_comb begin
        st_fail     = safe_out_valid_i && (safe_out_i == ST_PASS_FAIL);
        st_ok       = safe_out_valid_i && (safe_out_i == ST_PASS_OK);
        st_release  = safe_out_valid_i && ((safe_out_i == ST_PASS_FAIL) ||
                      (safe_out_i == ST_TIMEOUT) || (safe_out_i == ST_CLOSE));
        trip        = (fail_q == MAX_F);
        release_own = st_release || trip ||
                      (owner_valid_q && (idle_q == IDLE_LAST) && !xfer);
    end

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        gap_d         = gap_q;
        last_d        = last_q;
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        idle_d        = idle_q;
        fail_d        = fail_q;
        lockout_d     = lockout_q;
        lock_d        = lock_q;
        bad_key_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (xfer_key == KEY_BAD) begin
                        bad_key_d = 1'b1;
                    end else begin
                        key_d   = xfer_key;
                        state_d = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = S_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer) last_d = xfer_idx;

        if (trip)                            fail_d = 3'd0;
        else if (st_fail && (fail_q < MAX_F)) fail_d = fail_q + 3'd1;
        else if (st_ok)                      fail_d = 3'd0;

        if (trip) begin
            lockout_d = 1'b1;
            lock_d    = LOCK_LOAD;
        end else if (lockout_q) begin
            if (lock_q <= LW'(1)) begin
                lockout_d = 1'b0;
                lock_d    = '0;
            end else begin
                lock_d = lock_q - LW'(1);
            end
        end

        // Release outranks a same-cycle owner-taking accept.
        if (owner_valid_q) begin
            if (release_own) begin
                owner_valid_d = 1'b0;
                owner_d       = 1'b0;
                idle_d        = '0;
            end else if (xfer) begin
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else if (xfer && !xfer_key[2] && !release_own) begin
            owner_valid_d = 1'b1;
            owner_d       = xfer_idx;
            idle_d        = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q       <= S_IDLE;
            key_q         <= 3'd0;
            gap_q         <= 4'd0;
            last_q        <= 1'b1;
            owner_valid_q <= 1'b0;
            owner_q       <= 1'b0;
            idle_q        <= '0;
            fail_q        <= 3'd0;
            lockout_q     <= 1'b0;
            lock_q        <= '0;
            bad_key_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            gap_q         <= gap_d;
            last_q        <= last_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            idle_q        <= idle_d;
            fail_q        <= fail_d;
            lockout_q     <= lockout_d;
            lock_q        <= lock_d;
            bad_key_q     <= bad_key_d;
        end
    end

    logic pulse;
    assign pulse       = (state_q == S_PULSE);
    assign KEY_0       = pulse && (key_q == 3'd0);
    assign KEY_1       = pulse && (key_q == 3'd1);
    assign KEY_2       = pulse && (key_q == 3'd2);
    assign KEY_3       = pulse && (key_q == 3'd3);
    assign KEY_OK      = pulse && (key_q == 3'd4);
    assign KEY_CLEAR   = pulse && (key_q == 3'd5);
    assign DOOR_SEALED = pulse && (key_q == 3'd6);

    assign owner_valid_o = owner_valid_q;
    assign owner_o       = owner_q;
    assign lockout_o     = lockout_q;
    assign fail_cnt_o    = fail_q;
    assign bad_key_o     = bad_key_q;
endmodule

// File: tb/tb_safe_key_arb.sv
// tb/tb_safe_key_arb.sv - directed self-checking bench for safe_key_arb
module tb_safe_key_arb;
    logic       clk_i = 1'b0;
    logic       arst_n_i;
    logic [2:0] safe_out_i;
    logic       safe_out_valid_i;
    logic       KEY_0, KEY_1, KEY_2, KEY_3, KEY_OK, KEY_CLEAR, DOOR_SEALED;
    logic       owner_valid_o, owner_o, lockout_o, bad_key_o;
    logic [2:0] fail_cnt_o;
    int         vectors = 0;
    int         miscompares = 0;

    safe_key_arb_if req_if();

    safe_key_arb dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .req_if(req_if),
        .KEY_0(KEY_0), .KEY_1(KEY_1), .KEY_2(KEY_2), .KEY_3(KEY_3),
        .KEY_OK(KEY_OK), .KEY_CLEAR(KEY_CLEAR), .DOOR_SEALED(DOOR_SEALED),
        .safe_out_i(safe_out_i), .safe_out_valid_i(safe_out_valid_i),
        .owner_valid_o(owner_valid_o), .owner_o(owner_o), .lockout_o(lockout_o),
        .fail_cnt_o(fail_cnt_o), .bad_key_o(bad_key_o)
    );

    wire [6:0]  keys = {DOOR_SEALED, KEY_CLEAR, KEY_OK, KEY_3, KEY_2, KEY_1, KEY_0};
    wire [15:0] all_out = {keys, req_if.req0_ready_o, req_if.req1_ready_o, owner_valid_o,
                           owner_o, lockout_o, fail_cnt_o, bad_key_o};

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [2:0] k);
        if (idx == 0) begin
            req_if.req0_valid_i = v;
            req_if.req0_key_i   = k;
        end else begin
            req_if.req1_valid_i = v;
            req_if.req1_key_i   = k;
        end
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        set_req(0, 1'b0, 3'd0);
        set_req(1, 1'b0, 3'd0);
        safe_out_i = 3'd0;
        safe_out_valid_i = 1'b0;
        step();
        step();
        arst_n_i = 1'b1;
    endtask

    task automatic send_key(input int idx, input logic [2:0] k);
        bit done = 1'b0;
        set_req(idx, 1'b1, k);
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (idx == 0 ? req_if.req0_ready_o : req_if.req1_ready_o) done = 1'b1;
            step();
        end
        set_req(idx, 1'b0, 3'd0);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL send_key: req%0d key %0d not accepted within 50 cycles", idx, k);
        end
    endtask

    task automatic safe_report(input logic [2:0] code);
        safe_out_i = code;
        safe_out_valid_i = 1'b1;
        step();
        safe_out_valid_i = 1'b0;
        safe_out_i = 3'd0;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0;
        set_req(0, 1'b1, 3'd1);
        set_req(1, 1'b1, 3'd2);
        safe_out_i = 3'd0;
        safe_out_valid_i = 1'b0;
        #1;
        vectors++;
        if (all_out !== 16'h0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0000", all_out); end
        step();
        vectors++;
        if (req_if.req0_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", req_if.req0_ready_o); end
        do_reset();
    endtask

    task automatic test_first_grant();
        do_reset();
        set_req(0, 1'b1, 3'd2);
        set_req(1, 1'b1, 3'd1);
        #1;
        vectors++;
        if ({req_if.req0_ready_o, req_if.req1_ready_o} !== 2'b10) begin miscompares++; $display("FAIL first_grant_ready: got %b want 10", {req_if.req0_ready_o, req_if.req1_ready_o}); end
        step();
        set_req(0, 1'b0, 3'd0);
        #1;
        vectors++;
        if (keys !== 7'b0000100) begin miscompares++; $display("FAIL first_grant_pulse: got %b want 0000100", keys); end
        vectors++;
        if ({owner_valid_o, owner_o} !== 2'b10) begin miscompares++; $display("FAIL first_grant_owner: got %b want 10", {owner_valid_o, owner_o}); end
        step();
        vectors++;
        if (keys !== 7'b0) begin miscompares++; $display("FAIL first_grant_gap: got %b want 0", keys); end
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            vectors++;
            if (req_if.req1_ready_o !== 1'b0) begin miscompares++; $display("FAIL first_grant_nonowner_%0d: got %b want 0", i, req_if.req1_ready_o); end
        end
        set_req(1, 1'b0, 3'd0);
    endtask

    task automatic test_owner_session();
        do_reset();
        send_key(0, 3'd1);
        send_key(0, 3'd2);
        send_key(0, 3'd4);
        vectors++;
        if ({owner_valid_o, owner_o} !== 2'b10) begin miscompares++; $display("FAIL session_owner: got %b want 10", {owner_valid_o, owner_o}); end
        safe_report(3'd4);
        vectors++;
        if ({owner_valid_o, fail_cnt_o} !== 4'b0001) begin miscompares++; $display("FAIL session_passfail: got %b want 0001", {owner_valid_o, fail_cnt_o}); end
        send_key(0, 3'd0);
        safe_report(3'd3);
        vectors++;
        if ({owner_valid_o, fail_cnt_o} !== 4'b1000) begin miscompares++; $display("FAIL session_passok: got %b want 1000", {owner_valid_o, fail_cnt_o}); end
        send_key(0, 3'd6);
        vectors++;
        if (DOOR_SEALED !== 1'b1) begin miscompares++; $display("FAIL session_sealed_pulse: got %b want 1", DOOR_SEALED); end
        safe_report(3'd6);
        vectors++;
        if ({owner_valid_o, fail_cnt_o} !== 4'b0000) begin miscompares++; $display("FAIL session_close: got %b want 0000", {owner_valid_o, fail_cnt_o}); end
    endtask

    task automatic test_lockout();
        int n = 0;
        bit bad = 1'b0;
        do_reset();
        send_key(0, 3'd3);
        for (int i = 1; i <= 3; i++) begin
            safe_report(3'd4);
            vectors++;
            if (fail_cnt_o !== 3'(i)) begin miscompares++; $display("FAIL lockout_failcnt_%0d: got %0d want %0d", i, fail_cnt_o, i); end
        end
        vectors++;
        if (lockout_o !== 1'b0) begin miscompares++; $display("FAIL lockout_early: got %b want 0", lockout_o); end
        step();
        vectors++;
        if ({lockout_o, fail_cnt_o, owner_valid_o} !== 5'b10000) begin miscompares++; $display("FAIL lockout_entry: got %b want 10000", {lockout_o, fail_cnt_o, owner_valid_o}); end
        set_req(0, 1'b1, 3'd2);
        while (lockout_o && n < 1100) begin
            #1;
            if (req_if.req0_ready_o || req_if.req1_ready_o) bad = 1'b1;
            n++;
            step();
        end
        vectors++;
        if (n !== 1000) begin miscompares++; $display("FAIL lockout_duration: got %0d want 1000", n); end
        vectors++;
        if (bad !== 1'b0) begin miscompares++; $display("FAIL lockout_ready: got %b want 0", bad); end
        #1;
        vectors++;
        if (req_if.req0_ready_o !== 1'b1) begin miscompares++; $display("FAIL lockout_resume: got %b want 1", req_if.req0_ready_o); end
        step();
        set_req(0, 1'b0, 3'd0);
    endtask

    task automatic test_owner_idle();
        int n = 0;
        bit bad = 1'b0;
        do_reset();
        send_key(0, 3'd3);
        set_req(1, 1'b1, 3'd0);
        while (owner_valid_o && n < 2100) begin
            #1;
            if (req_if.req1_ready_o) bad = 1'b1;
            n++;
            step();
        end
        vectors++;
        if (n !== 2000) begin miscompares++; $display("FAIL idle_duration: got %0d want 2000", n); end
        vectors++;
        if (bad !== 1'b0) begin miscompares++; $display("FAIL idle_nonowner_ready: got %b want 0", bad); end
        #1;
        vectors++;
        if (req_if.req1_ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_req1_ready: got %b want 1", req_if.req1_ready_o); end
        step();
        set_req(1, 1'b0, 3'd0);
        #1;
        vectors++;
        if ({owner_valid_o, owner_o, keys} !== 9'b11_0000001) begin miscompares++; $display("FAIL idle_new_owner: got %b want 110000001", {owner_valid_o, owner_o, keys}); end
    endtask

    task automatic test_bad_key();
        do_reset();
        safe_report(3'd4);
        set_req(0, 1'b1, 3'd7);
        #1;
        vectors++;
        if (req_if.req0_ready_o !== 1'b1) begin miscompares++; $display("FAIL bad_ready: got %b want 1", req_if.req0_ready_o); end
        step();
        set_req(0, 1'b1, 3'd1);
        #1;
        vectors++;
        if ({bad_key_o, keys, owner_valid_o, req_if.req0_ready_o} !== 10'b1_0000000_0_1) begin miscompares++; $display("FAIL bad_pulse: got %b want 1000000001", {bad_key_o, keys, owner_valid_o, req_if.req0_ready_o}); end
        step();
        set_req(0, 1'b0, 3'd0);
        #1;
        vectors++;
        if ({bad_key_o, keys, owner_valid_o} !== 9'b0_0000010_1) begin miscompares++; $display("FAIL bad_followup: got %b want 000000101", {bad_key_o, keys, owner_valid_o}); end
        step();
        vectors++;
        if ({keys, owner_valid_o, fail_cnt_o} !== 11'b0000000_1_001) begin miscompares++; $display("FAIL gap_state: got %b want 00000001001", {keys, owner_valid_o, fail_cnt_o}); end
        arst_n_i = 1'b0;
        #1;
        vectors++;
        if (all_out !== 16'h0) begin miscompares++; $display("FAIL reset_mid_gap: got %h want 0000", all_out); end
        step();
        arst_n_i = 1'b1;
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        send_key(0, 3'd4);
        vectors++;
        if (keys !== 7'b0010000) begin miscompares++; $display("FAIL pulse_ok: got %b want 0010000", keys); end
        arst_n_i = 1'b0;
        #1;
        vectors++;
        if (keys !== 7'b0) begin miscompares++; $display("FAIL reset_mid_pulse: got %b want 0", keys); end
        step();
        arst_n_i = 1'b1;
        step();
        vectors++;
        if (keys !== 7'b0) begin miscompares++; $display("FAIL pulse_discarded: got %b want 0", keys); end
        set_req(0, 1'b1, 3'd0);
        set_req(1, 1'b1, 3'd1);
        #1;
        vectors++;
        if ({req_if.req0_ready_o, req_if.req1_ready_o} !== 2'b10) begin miscompares++; $display("FAIL reset_last_ptr: got %b want 10", {req_if.req0_ready_o, req_if.req1_ready_o}); end
        step();
        set_req(0, 1'b0, 3'd0);
        set_req(1, 1'b0, 3'd0);
    endtask

    task automatic test_alternate();
        do_reset();
        set_req(0, 1'b1, 3'd4);
        set_req(1, 1'b1, 3'd5);
        #1;
        vectors++;
        if ({req_if.req0_ready_o, req_if.req1_ready_o} !== 2'b10) begin miscompares++; $display("FAIL alt_first: got %b want 10", {req_if.req0_ready_o, req_if.req1_ready_o}); end
        step();
        step();
        step();
        #1;
        vectors++;
        if ({req_if.req0_ready_o, req_if.req1_ready_o, owner_valid_o} !== 3'b010) begin miscompares++; $display("FAIL alt_second: got %b want 010", {req_if.req0_ready_o, req_if.req1_ready_o, owner_valid_o}); end
        step();
        vectors++;
        if (keys !== 7'b0100000) begin miscompares++; $display("FAIL alt_clear_pulse: got %b want 0100000", keys); end
        step();
        step();
        vectors++;
        if ({req_if.req0_ready_o, req_if.req1_ready_o} !== 2'b10) begin miscompares++; $display("FAIL alt_third: got %b want 10", {req_if.req0_ready_o, req_if.req1_ready_o}); end
        set_req(0, 1'b0, 3'd0);
        set_req(1, 1'b0, 3'd0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] rdy_pat;
        logic [7:0] key_pat;
        do_reset();
        set_req(0, 1'b1, 3'd1);
        for (int i = 0; i < 8; i++) begin
            #1;
            rdy_pat[i] = req_if.req0_ready_o;
            key_pat[i] = KEY_1;
            step();
        end
        set_req(0, 1'b0, 3'd0);
        vectors++;
        if (rdy_pat !== 8'b0100_1001) begin miscompares++; $display("FAIL b2b_ready: got %b want 01001001", rdy_pat); end
        vectors++;
        if (key_pat !== 8'b1001_0010) begin miscompares++; $display("FAIL b2b_pulse: got %b want 10010010", key_pat); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_grant();
        test_owner_session();
        test_lockout();
        test_owner_idle();
        test_bad_key();
        test_reset_mid_pulse();
        test_alternate();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
